// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory wait timeout
// Optional CTRL_ILLEGAL_TRAP_EN: illegal opcodes park the FSM in TRAP instead of retiring as a NOP.
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int WAIT_W   = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                Branch,
    output logic                IorD,
    output logic                IRWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          Jump,
    output logic                instr_done,
    output logic                mem_timeout,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_IALU, C_LD, C_ST, C_BR, C_J, C_JAL, C_JR, C_ILL
    } class_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX_C = WAIT_W'(WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    function automatic class_t op_class(input logic [OPCODE_W-1:0] op);
        op_class = C_ILL;
        case (op)
            6'b000000:                                              op_class = C_R;
            6'b001000, 6'b111111, 6'b001100,
            6'b001101, 6'b001010, 6'b001111:                        op_class = C_IALU;
            6'b100011, 6'b100001, 6'b100000:                        op_class = C_LD;
            6'b101011, 6'b101001, 6'b101000:                        op_class = C_ST;
            6'b000100, 6'b000101, 6'b000001:                        op_class = C_BR;
            6'b000010:                                              op_class = C_J;
            6'b000011:                                              op_class = C_JAL;
            6'b111110:                                              op_class = C_JR;
            default:                                                op_class = C_ILL;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                timeout_q, timeout_d;

    class_t cls, dec_cls;
    logic   waiting;
    logic   pc_write, branch, iord, ir_write, mem_read, mem_write;
    logic   mem_to_reg, reg_dst, reg_write, alu_src_a, done;
    logic [1:0] alu_src_b, alu_op, jump;

    assign cls     = op_class(op_q);
    assign dec_cls = op_class(opcode);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            op_q       <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        jump       = 2'b00;
        done       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d      = opcode;
                alu_src_b = 2'b11;
                if (dec_cls == C_ILL) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    done    = 1'b1;
                    state_d = S_FETCH;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls)
                    C_R: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b10;
                        state_d   = S_WB;
                    end
                    C_IALU: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        alu_op    = 2'b11;
                        state_d   = S_WB;
                    end
                    C_LD, C_ST: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                        state_d   = S_MEM;
                    end
                    C_BR: begin
                        alu_src_a = 1'b1;
                        alu_op    = 2'b01;
                        branch    = 1'b1;
                        done      = 1'b1;
                        state_d   = S_FETCH;
                    end
                    C_J, C_JAL, C_JR: begin
                        pc_write  = 1'b1;
                        reg_write = (cls == C_JAL);
                        jump      = (cls == C_J) ? 2'b11 : ((cls == C_JAL) ? 2'b01 : 2'b10);
                        done      = 1'b1;
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                iord      = 1'b1;
                mem_read  = (cls == C_LD);
                mem_write = (cls != C_LD);
                if (mem_ready) begin
                    if (cls == C_LD) begin
                        state_d = S_WB;
                    end else begin
                        done    = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (cls == C_R);
                mem_to_reg = (cls == C_LD);
                done       = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Counter only runs while a memory access is stalled; any other cycle clears it.
    always_comb begin
        waiting    = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
        wait_cnt_d = '0;
        if (waiting) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX_C) ? wait_cnt_q : wait_cnt_q + WAIT_ONE;
        end
        timeout_d = timeout_q | (waiting && (wait_cnt_d == WAIT_MAX_C));
    end

    // Strobes are gated by reset so an in-flight write is dropped the moment reset rises.
    assign PCWrite     = pc_write  & ~reset;
    assign Branch      = branch    & ~reset;
    assign IRWrite     = ir_write  & ~reset;
    assign MemRead     = mem_read  & ~reset;
    assign MemWrite    = mem_write & ~reset;
    assign RegWrite    = reg_write & ~reset;
    assign instr_done  = done      & ~reset;
    assign IorD        = iord;
    assign MemtoReg    = mem_to_reg;
    assign RegDst      = reg_dst;
    assign ALUSrcA     = alu_src_a;
    assign ALUSrcB     = alu_src_b;
    assign ALUOp       = alu_op;
    assign Jump        = jump;
    assign mem_timeout = timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed testbench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, Branch, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, Jump;
    logic       instr_done, mem_timeout;
    logic [2:0] state;

    int n_assert = 0;
    int n_fail   = 0;

    multicycle_control #(.OPCODE_W(6), .WAIT_W(4), .WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .Jump(Jump), .instr_done(instr_done), .mem_timeout(mem_timeout), .state(state)
    );

    always #5 clk = ~clk;

    logic [20:0] ctl;
    assign ctl = {state, PCWrite, Branch, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, ALUOp, Jump, instr_done, mem_timeout};

    // f = {PCWrite,Branch,IorD,IRWrite,MemRead,MemWrite,MemtoReg,RegDst,RegWrite,ALUSrcA}
    function automatic logic [20:0] ev(input logic [2:0] st, input logic [9:0] f,
                                       input logic [1:0] asb, input logic [1:0] aop,
                                       input logic [1:0] jmp, input logic dn);
        return {st, f, asb, aop, jmp, dn, 1'b0};
    endfunction

    localparam logic [20:0] RST      = ev(3'd0, 10'b0000000000, 2'b01, 2'b00, 2'b00, 1'b0);
    localparam logic [20:0] F_RDY    = ev(3'd0, 10'b1001100000, 2'b01, 2'b00, 2'b00, 1'b0);
    localparam logic [20:0] F_WAIT   = ev(3'd0, 10'b0000100000, 2'b01, 2'b00, 2'b00, 1'b0);
    localparam logic [20:0] DEC      = ev(3'd1, 10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0);
    localparam logic [20:0] DEC_NOP  = ev(3'd1, 10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b1);
    localparam logic [20:0] R_EX     = ev(3'd2, 10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0);
    localparam logic [20:0] R_WB     = ev(3'd4, 10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b1);
    localparam logic [20:0] IA_EX    = ev(3'd2, 10'b0000000001, 2'b10, 2'b11, 2'b00, 1'b0);
    localparam logic [20:0] IA_WB    = ev(3'd4, 10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b1);
    localparam logic [20:0] LS_EX    = ev(3'd2, 10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0);
    localparam logic [20:0] LD_MEM   = ev(3'd3, 10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0);
    localparam logic [20:0] LD_WB    = ev(3'd4, 10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b1);
    localparam logic [20:0] ST_MEM_W = ev(3'd3, 10'b0010010000, 2'b00, 2'b00, 2'b00, 1'b0);
    localparam logic [20:0] ST_MEM_R = ev(3'd3, 10'b0010010000, 2'b00, 2'b00, 2'b00, 1'b1);
    localparam logic [20:0] BR_EX    = ev(3'd2, 10'b0100000001, 2'b00, 2'b01, 2'b00, 1'b1);
    localparam logic [20:0] J_EX     = ev(3'd2, 10'b1000000000, 2'b00, 2'b00, 2'b11, 1'b1);
    localparam logic [20:0] JAL_EX   = ev(3'd2, 10'b1000000010, 2'b00, 2'b00, 2'b01, 1'b1);
    localparam logic [20:0] JR_EX    = ev(3'd2, 10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b1);
    localparam logic [20:0] TRAP     = ev(3'd5, 10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b0);
    localparam logic [20:0] TO       = 21'd1;

    task automatic chk(input string tag, input logic [20:0] exp);
        n_assert++;
        assert (ctl === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, ctl, exp);
        end
    endtask

    // Entered at posedge+1: drive inputs, check the settled outputs, advance one cycle.
    task automatic cyc(input string tag, input logic rdy, input logic [5:0] op, input logic [20:0] exp);
        mem_ready = rdy;
        opcode    = op;
        #1;
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        @(posedge clk);
        #1;
        chk("reset_state", RST);
        reset = 1'b0;

        cyc("add_fetch",  1'b1, 6'b000000, F_RDY);
        cyc("add_decode", 1'b1, 6'b000000, DEC);
        cyc("add_exec",   1'b1, 6'b000000, R_EX);
        cyc("add_wb",     1'b1, 6'b000000, R_WB);

        cyc("lw_fetch",   1'b1, 6'b100011, F_RDY);
        cyc("lw_decode",  1'b1, 6'b100011, DEC);
        cyc("lw_exec",    1'b1, 6'b100011, LS_EX);
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1'b0, 6'b100011, LD_MEM);
        cyc("lw_mem_rdy", 1'b1, 6'b100011, LD_MEM);
        cyc("lw_wb",      1'b1, 6'b100011, LD_WB);

        cyc("sw_fetch",   1'b1, 6'b101011, F_RDY);
        cyc("sw_decode",  1'b1, 6'b101011, DEC);
        cyc("sw_exec",    1'b1, 6'b101011, LS_EX);
        cyc("sw_mem",     1'b1, 6'b101011, ST_MEM_R);

        cyc("jal_fetch",  1'b1, 6'b000011, F_RDY);
        cyc("jal_decode", 1'b1, 6'b000011, DEC);
        cyc("jal_exec",   1'b1, 6'b000011, JAL_EX);

        cyc("beq_fetch",  1'b1, 6'b000100, F_RDY);
        cyc("beq_decode", 1'b1, 6'b000100, DEC);
        cyc("beq_exec",   1'b1, 6'b000100, BR_EX);

        cyc("addi_fetch", 1'b1, 6'b001000, F_RDY);
        cyc("addi_decode",1'b1, 6'b001000, DEC);
        cyc("addi_exec",  1'b1, 6'b001000, IA_EX);
        cyc("addi_wb",    1'b1, 6'b001000, IA_WB);

        cyc("j_fetch",    1'b1, 6'b000010, F_RDY);
        cyc("j_decode",   1'b1, 6'b000010, DEC);
        cyc("j_exec",     1'b1, 6'b000010, J_EX);

        cyc("jr_fetch",   1'b1, 6'b111110, F_RDY);
        cyc("jr_decode",  1'b1, 6'b111110, DEC);
        cyc("jr_exec",    1'b1, 6'b111110, JR_EX);

        for (int i = 1; i <= 20; i++)
            cyc("fetch_timeout", 1'b0, 6'b110011, (i >= 16) ? (F_WAIT | TO) : F_WAIT);

        cyc("ill_fetch",  1'b1, 6'b110011, F_RDY | TO);
`ifdef CTRL_ILLEGAL_TRAP_EN
        cyc("ill_decode", 1'b1, 6'b110011, DEC | TO);
        for (int i = 0; i < 3; i++) cyc("trap_hold", 1'b1, 6'b110011, TRAP | TO);
`else
        cyc("ill_decode", 1'b1, 6'b110011, DEC_NOP | TO);
        cyc("ill_next",   1'b1, 6'b110011, F_RDY | TO);
`endif

        mem_ready = 1'b0;
        reset     = 1'b1;
        #1;
        chk("timeout_reset", RST);
        @(posedge clk);
        #1;
        reset = 1'b0;

        cyc("sw2_fetch",  1'b1, 6'b101011, F_RDY);
        cyc("sw2_decode", 1'b1, 6'b101011, DEC);
        cyc("sw2_exec",   1'b1, 6'b101011, LS_EX);
        cyc("sw2_mem_wait", 1'b0, 6'b101011, ST_MEM_W);
        mem_ready = 1'b0;
        #1;
        chk("sw2_mem_wait2", ST_MEM_W);
        reset = 1'b1;
        #1;
        chk("sw2_abort", RST);
        @(posedge clk);
        #1;
        chk("sw2_abort_hold", RST);
        reset = 1'b0;

        cyc("add2_fetch",  1'b1, 6'b000000, F_RDY);
        cyc("add2_decode", 1'b1, 6'b000000, DEC);
        cyc("add2_exec",   1'b1, 6'b000000, R_EX);
        cyc("add2_wb",     1'b1, 6'b000000, R_WB);
        cyc("add2_next",   1'b1, 6'b000000, F_RDY);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
